// File: rtl/alu_seq.sv
// alu_seq: multi-cycle RV32-style ALU with iterative shifts behind a valid/ready handshake.
// Optional feature: define ALU_SEQ_MUL_EN to turn op 0101 into a shift-add multiplier.
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iDataA,
  input  logic [WIDTH-1:0] iDataB,
  input  logic [3:0]       iAluOp,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oData,
  output logic             oZero,
  output logic             oLt,
  output logic             oLtu,
  output logic             oIllegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int STW = $clog2(SHIFT_STEP);
  localparam int RW  = (STW == 0) ? 1 : STW;
  localparam int AW  = STW + 1;
  localparam int CW  = SHW + 1;
  localparam logic [RW-1:0] REM_MASK = (STW == 0) ? '0 : '1;

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b1000, OP_SLL = 4'b0001,
                         OP_SRL = 4'b1001, OP_SRA = 4'b1101, OP_SLT = 4'b0010,
                         OP_SLTU = 4'b0011, OP_XOR = 4'b0100, OP_OR = 4'b0110,
                         OP_AND = 4'b0111;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b0101;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [WIDTH-1:0] rc_sum(input logic [WIDTH-1:0] x, y, input logic cin);
    logic c;
    logic [WIDTH-1:0] s;
    c = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return s;
  endfunction

  function automatic logic rc_cout(input logic [WIDTH-1:0] x, y, input logic cin);
    logic c;
    c = cin;
    for (int i = 0; i < WIDTH; i++) c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    return c;
  endfunction

  function automatic logic [CW-1:0] cnt_dec(input logic [CW-1:0] v);
    logic bw;
    logic [CW-1:0] r;
    bw = 1'b1;
    for (int i = 0; i < CW; i++) begin
      r[i] = v[i] ^ bw;
      bw   = bw & ~v[i];
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
    logic cy;
    logic [CW-1:0] r;
    cy = 1'b1;
    for (int i = 0; i < CW; i++) begin
      r[i] = v[i] ^ cy;
      cy   = cy & v[i];
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic             ready_q, ready_d, valid_q, valid_d;
  logic [WIDTH-1:0] res_q, res_d, work_q, work_d;
  logic             zero_q, zero_d, lt_q, lt_d, ltu_q, ltu_d, ill_q, ill_d;
  logic [3:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    rem_q, rem_d;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] acc_q, acc_d, mulb_q, mulb_d;
`endif

  // Accept-side decode: compare flags and the shift iteration count come straight from the operands.
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic [RW-1:0]    rem_in;
  logic [CW-1:0]    quo, cnt_in;
  logic             in_lt, in_ltu;

  assign diff   = rc_sum(iDataA, ~iDataB, 1'b1);
  assign in_ltu = ~rc_cout(iDataA, ~iDataB, 1'b1);
  assign in_lt  = (iDataA[WIDTH-1] ^ iDataB[WIDTH-1]) ? iDataA[WIDTH-1] : diff[WIDTH-1];
  assign shamt  = iDataB[SHW-1:0];
  assign rem_in = shamt[RW-1:0] & REM_MASK;
  assign quo    = CW'(shamt[SHW-1:STW]);
  assign cnt_in = (rem_in != '0) ? cnt_inc(quo) : quo;

  // One candidate per possible step size; the partial step (remainder) is taken on the last iteration.
  logic             shift_left, fill;
  logic [AW-1:0]    amt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] cand_l [1:SHIFT_STEP];
  logic [WIDTH-1:0] cand_r [1:SHIFT_STEP];

  assign shift_left = (op_q == OP_SLL);
  assign fill       = (op_q == OP_SRA) & work_q[WIDTH-1];

  for (genvar m = 1; m <= SHIFT_STEP; m++) begin : g_cand
    assign cand_l[m] = {work_q[WIDTH-1-m:0], {m{1'b0}}};
    assign cand_r[m] = {{m{fill}}, work_q[WIDTH-1:m]};
  end

  always_comb begin
    amt     = ((cnt_q == CW'(1)) && (rem_q != '0)) ? AW'(rem_q) : AW'(SHIFT_STEP);
    shifted = work_q;
    for (int m = 1; m <= SHIFT_STEP; m++)
      if (amt == AW'(m)) shifted = shift_left ? cand_l[m] : cand_r[m];
  end

  always_comb begin
    logic [WIDTH-1:0] fin;
    state_d = state_q;
    ready_d = ready_q;
    valid_d = valid_q;
    res_d   = res_q;
    work_d  = work_q;
    zero_d  = zero_q;
    lt_d    = lt_q;
    ltu_d   = ltu_q;
    ill_d   = ill_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    fin     = shifted;
`ifdef ALU_SEQ_MUL_EN
    acc_d   = acc_q;
    mulb_d  = mulb_q;
`endif
    case (state_q)
      IDLE: begin
        if (iValid) begin
          op_d    = iAluOp;
          lt_d    = in_lt;
          ltu_d   = in_ltu;
          ill_d   = 1'b0;
          work_d  = iDataA;
          res_d   = '0;
          state_d = DONE;
          valid_d = 1'b1;
          ready_d = 1'b0;
          case (iAluOp)
            OP_ADD:  res_d = rc_sum(iDataA, iDataB, 1'b0);
            OP_SUB:  res_d = diff;
            OP_SLT:  res_d = WIDTH'(in_lt);
            OP_SLTU: res_d = WIDTH'(in_ltu);
            OP_XOR:  res_d = iDataA ^ iDataB;
            OP_OR:   res_d = iDataA | iDataB;
            OP_AND:  res_d = iDataA & iDataB;
            OP_SLL, OP_SRL, OP_SRA: begin
              if (shamt == '0) begin
                res_d = iDataA;
              end else begin
                state_d = BUSY;
                valid_d = 1'b0;
                cnt_d   = cnt_in;
                rem_d   = rem_in;
              end
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
              state_d = BUSY;
              valid_d = 1'b0;
              cnt_d   = CW'(WIDTH);
              rem_d   = '0;
              acc_d   = '0;
              mulb_d  = iDataB;
            end
`endif
            default: ill_d = 1'b1;
          endcase
          zero_d = ~|res_d;
        end
      end
      BUSY: begin
        cnt_d = cnt_dec(cnt_q);
`ifdef ALU_SEQ_MUL_EN
        if (op_q == OP_MUL) begin
          acc_d  = mulb_q[0] ? rc_sum(acc_q, work_q, 1'b0) : acc_q;
          work_d = {work_q[WIDTH-2:0], 1'b0};
          mulb_d = {1'b0, mulb_q[WIDTH-1:1]};
          fin    = acc_d;
        end else
`endif
        begin
          work_d = shifted;
        end
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          valid_d = 1'b1;
          res_d   = fin;
          zero_d  = ~|fin;
        end
      end
      DONE: begin
        if (iReady) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    work_q <= work_d;
`ifdef ALU_SEQ_MUL_EN
    acc_q  <= acc_d;
    mulb_q <= mulb_d;
`endif
    if (iRst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      lt_q    <= 1'b0;
      ltu_q   <= 1'b0;
      ill_q   <= 1'b0;
      op_q    <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      lt_q    <= lt_d;
      ltu_q   <= ltu_d;
      ill_q   <= ill_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
    end
  end

  assign oReady   = ready_q;
  assign oValid   = valid_q;
  assign oData    = res_q;
  assign oZero    = zero_q;
  assign oLt      = lt_q;
  assign oLtu     = ltu_q;
  assign oIllegal = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Table-driven bench for alu_seq (SHIFT_STEP=1 main instance, SHIFT_STEP=4 side instance).
module tb_alu_seq;
  localparam int W = 32;
  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b1000, SLL = 4'b0001, SRL = 4'b1001,
                         SRA = 4'b1101, SLT = 4'b0010, SLTU = 4'b0011, XOR_ = 4'b0100,
                         OR_ = 4'b0110, AND_ = 4'b0111, MULOP = 4'b0101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, vld, vld4, rdy;
  logic [W-1:0] a, b;
  logic [3:0] op;
  logic o_rdy, o_vld, o_zero, o_lt, o_ltu, o_ill;
  logic [W-1:0] o_data;
  logic o_rdy4, o_vld4, o_zero4, o_lt4, o_ltu4, o_ill4;
  logic [W-1:0] o_data4;

  int n_cmp = 0, n_bad = 0;

  alu_seq #(.WIDTH(W), .SHIFT_STEP(1)) dut (
    .iClk(clk), .iRst(rst), .iValid(vld), .oReady(o_rdy), .iDataA(a), .iDataB(b),
    .iAluOp(op), .oValid(o_vld), .iReady(rdy), .oData(o_data), .oZero(o_zero),
    .oLt(o_lt), .oLtu(o_ltu), .oIllegal(o_ill));

  alu_seq #(.WIDTH(W), .SHIFT_STEP(4)) dut4 (
    .iClk(clk), .iRst(rst), .iValid(vld4), .oReady(o_rdy4), .iDataA(a), .iDataB(b),
    .iAluOp(op), .oValid(o_vld4), .iReady(1'b1), .oData(o_data4), .oZero(o_zero4),
    .oLt(o_lt4), .oLtu(o_ltu4), .oIllegal(o_ill4));

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, d;
    int           lat;
    logic         z, lt, ltu, ill;
  } vec_t;

  localparam int NV = 19;
  vec_t v [NV];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int t = 0;
    while (o_rdy !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_at_issue", o_rdy, 1);
    op = o; a = x; b = y; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit busy_rdy);
    lat = 1;
    busy_rdy = 1'b0;
    while (o_vld !== 1'b1 && lat < 100) begin
      if (o_rdy !== 1'b0) busy_rdy = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run4(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      output int lat, output bit busy_rdy);
    op = o; a = x; b = y; vld4 = 1'b1;
    @(negedge clk);
    vld4 = 1'b0;
    lat = 1;
    busy_rdy = 1'b0;
    while (o_vld4 !== 1'b1 && lat < 100) begin
      if (o_rdy4 !== 1'b0) busy_rdy = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bit brdy;

    v[0]  = '{ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1,  1'b1, 1'b1, 1'b0, 1'b0};
    v[1]  = '{SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1,  1'b1, 1'b0, 1'b0, 1'b0};
    v[2]  = '{SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1,  1'b0, 1'b1, 1'b0, 1'b0};
    v[3]  = '{SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1,  1'b1, 1'b1, 1'b0, 1'b0};
    v[4]  = '{XOR_, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1,  1'b0, 1'b1, 1'b1, 1'b0};
    v[5]  = '{OR_,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1,  1'b0, 1'b0, 1'b0, 1'b0};
    v[6]  = '{AND_, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1,  1'b0, 1'b1, 1'b0, 1'b0};
    v[7]  = '{SLL,  32'h12345678, 32'h00000000, 32'h12345678, 1,  1'b0, 1'b0, 1'b0, 1'b0};
    v[8]  = '{SLL,  32'h00000001, 32'h00000004, 32'h00000010, 5,  1'b0, 1'b1, 1'b1, 1'b0};
    v[9]  = '{SRL,  32'h80000000, 32'h00000023, 32'h10000000, 4,  1'b0, 1'b1, 1'b0, 1'b0};
    v[10] = '{SRA,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 32, 1'b0, 1'b1, 1'b0, 1'b0};
    v[11] = '{SRA,  32'h40000000, 32'h00000002, 32'h10000000, 3,  1'b0, 1'b0, 1'b0, 1'b0};
    v[12] = '{ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1,  1'b0, 1'b0, 1'b0, 1'b0};
    v[13] = '{4'hF, 32'h00000003, 32'h00000003, 32'h00000000, 1,  1'b1, 1'b0, 1'b0, 1'b1};
    v[14] = '{SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1,  1'b0, 1'b1, 1'b1, 1'b0};
    v[15] = '{SRL,  32'hFFFFFFFF, 32'h00000004, 32'h0FFFFFFF, 5,  1'b0, 1'b1, 1'b0, 1'b0};
    v[16] = '{4'hA, 32'h00000007, 32'h00000002, 32'h00000000, 1,  1'b1, 1'b0, 1'b0, 1'b1};
`ifdef ALU_SEQ_MUL_EN
    v[17] = '{MULOP, 32'h00010001, 32'h00010001, 32'h00020001, 33, 1'b0, 1'b0, 1'b0, 1'b0};
    v[18] = '{MULOP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    v[17] = '{MULOP, 32'h00010001, 32'h00010001, 32'h00000000, 1, 1'b1, 1'b0, 1'b0, 1'b1};
    v[18] = '{MULOP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 1'b1, 1'b0, 1'b0, 1'b1};
`endif

    rst = 1'b1; vld = 1'b0; vld4 = 1'b0; rdy = 1'b1;
    op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", o_rdy, 1);
    chk("rst_valid", o_vld, 0);
    chk("rst_data", o_data, 0);
    chk("rst_flags", {o_zero, o_lt, o_ltu, o_ill}, 0);

    for (int i = 0; i < NV; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_valid(lat, brdy);
      chk($sformatf("v%0d_latency", i), lat, v[i].lat);
      chk($sformatf("v%0d_data", i), o_data, v[i].d);
      chk($sformatf("v%0d_zero", i), o_zero, v[i].z);
      chk($sformatf("v%0d_lt", i), o_lt, v[i].lt);
      chk($sformatf("v%0d_ltu", i), o_ltu, v[i].ltu);
      chk($sformatf("v%0d_illegal", i), o_ill, v[i].ill);
      chk($sformatf("v%0d_ready_while_busy", i), brdy, 0);
      @(negedge clk);
      chk($sformatf("v%0d_ready_after", i), o_rdy, 1);
      chk($sformatf("v%0d_valid_after", i), o_vld, 0);
    end

    // SHIFT_STEP=4 instance: full-step and partial-step iterations
    run4(SRA, 32'h80000000, 32'd31, lat, brdy);
    chk("s4_sra_latency", lat, 9);
    chk("s4_sra_data", o_data4, 32'hFFFFFFFF);
    chk("s4_sra_flags", {o_zero4, o_lt4, o_ltu4, o_ill4}, 4'b0100);
    chk("s4_sra_ready_while_busy", brdy, 0);
    @(negedge clk);
    chk("s4_ready_after", o_rdy4, 1);
    run4(SRL, 32'hF0000000, 32'd6, lat, brdy);
    chk("s4_srl_latency", lat, 3);
    chk("s4_srl_data", o_data4, 32'h03C00000);
    @(negedge clk);

    // Backpressure: result held, new request ignored until transfer
    rdy = 1'b0;
    issue(XOR_, 32'hA5A5A5A5, 32'hFFFF0000);
    wait_valid(lat, brdy);
    chk("bp_latency", lat, 1);
    op = ADD; a = 32'd1; b = 32'd1; vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", k), o_vld, 1);
      chk($sformatf("bp_data_%0d", k), o_data, 32'h5A5AA5A5);
      chk($sformatf("bp_flags_%0d", k), {o_zero, o_lt, o_ltu}, 3'b011);
      chk($sformatf("bp_ready_%0d", k), o_rdy, 0);
    end
    vld = 1'b0; rdy = 1'b1;
    @(negedge clk);
    chk("bp_valid_after", o_vld, 0);
    chk("bp_ready_after", o_rdy, 1);
    @(negedge clk);
    chk("bp_no_ghost_op", o_vld, 0);

    // Reset mid-shift aborts the operation
    issue(SRL, 32'hFFFFFFFF, 32'd20);
    repeat (8) @(negedge clk);
    chk("abort_busy_before_rst", o_rdy, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", o_vld, 0);
    chk("abort_ready", o_rdy, 1);
    chk("abort_data", o_data, 0);
    chk("abort_flags", {o_zero, o_lt, o_ltu, o_ill}, 0);
    issue(ADD, 32'd2, 32'd3);
    wait_valid(lat, brdy);
    chk("post_abort_latency", lat, 1);
    chk("post_abort_data", o_data, 32'd5);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
